regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (WE3/A3/WD3) between two writeback

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_wb_arbiter_if.sv | 57 +++++
 rtl/regfile_wb_arbiter_rr_arb2.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter slice.
// Default widths, the hard-wired zero register and source encoding.
package regfile_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned REG_ZERO       = 0;

    // Writeback source index; doubles as the round-robin "last granted" state
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MUL = 1'b1
    } src_e;

    // Grant vector for a given source
    function automatic logic [1:0] src_onehot(input src_e src);
        return (src == SRC_MUL) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of writeback requests, reservation/hazard checks and the
// register-file write port shared between decode, the sources and the arbiter.
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;

    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;

    logic                  rsv_valid;
    logic [ADDR_WIDTH-1:0] rsv_addr;
    logic                  rsv_ready;

    logic [ADDR_WIDTH-1:0] chk_a1;
    logic [ADDR_WIDTH-1:0] chk_a2;
    logic                  hazard1;
    logic                  hazard2;

    logic                  we3;
    logic [ADDR_WIDTH-1:0] a3;
    logic [DATA_WIDTH-1:0] wd3;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        output rsv_valid, rsv_addr,
        input  rsv_ready,
        output chk_a1, chk_a2,
        input  hazard1, hazard2,
        input  we3, a3, wd3
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        input  rsv_valid, rsv_addr,
        output rsv_ready,
        input  chk_a1, chk_a2,
        output hazard1, hazard2,
        output we3, a3, wd3
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester is granted, a tie goes to
// the source that was not granted last. State moves only on a grant.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant_c
);

    src_e r_last_grant;
    src_e w_last_grant_nxt;

    // State register; reset favours req0 on the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= SRC_MUL;
        end else begin
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Next-state: remember whoever transferred this cycle
    always_comb begin
        w_last_grant_nxt = r_last_grant;
        if (o_grant_c[1]) begin
            w_last_grant_nxt = SRC_MUL;
        end else if (o_grant_c[0]) begin
            w_last_grant_nxt = SRC_ALU;
        end
    end

    // Grant decode
    always_comb begin
        o_grant_c = 2'b00;
        unique case (i_valid)
            2'b01:   o_grant_c = 2'b01;
            2'b10:   o_grant_c = 2'b10;
            2'b11:   o_grant_c = ~src_onehot(r_last_grant);
            default: o_grant_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the ALU and
// multi-cycle writeback paths and tracks pending writes for decode stalls.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [1:0]            w_valid;
    logic [1:0]            w_grant;
    logic                  w_xfer;
    logic                  w_wr_issue;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_rsv_ready;
    logic                  w_rsv_set;
    logic [NUM_REGS-1:0]   w_busy_nxt;

    logic                  r_we3;
    logic [ADDR_WIDTH-1:0] r_a3;
    logic [DATA_WIDTH-1:0] r_wd3;
    logic [NUM_REGS-1:0]   r_busy;

    // Requests are masked while in reset so no ready can leak out
    assign w_valid = {bus.req1_valid, bus.req0_valid} & {2{rst}};

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (w_valid),
        .o_grant_c (w_grant)
    );

    assign bus.req0_ready = w_grant[0];
    assign bus.req1_ready = w_grant[1];

    // Winner's payload; a transfer to the zero register is swallowed here
    always_comb begin
        w_xfer     = |w_grant;
        w_sel_addr = bus.req0_addr;
        w_sel_data = bus.req0_data;
        if (w_grant[1]) begin
            w_sel_addr = bus.req1_addr;
            w_sel_data = bus.req1_data;
        end
        w_wr_issue = w_xfer && (w_sel_addr != ZERO_ADDR);
    end

    // Registered write port; address/data hold when nothing is written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else begin
            r_we3 <= w_wr_issue;
            if (w_wr_issue) begin
                r_a3  <= w_sel_addr;
                r_wd3 <= w_sel_data;
            end
        end
    end

    assign bus.we3 = r_we3;
    assign bus.a3  = r_a3;
    assign bus.wd3 = r_wd3;

    assign w_rsv_ready   = rst & ~r_busy[bus.rsv_addr];
    assign w_rsv_set     = bus.rsv_valid && w_rsv_ready && (bus.rsv_addr != ZERO_ADDR);
    assign bus.rsv_ready = w_rsv_ready;

    // Retire on the cycle the write is presented, then apply new reservation
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we3) begin
            w_busy_nxt[r_a3] = 1'b0;
        end
        if (w_rsv_set) begin
            w_busy_nxt[bus.rsv_addr] = 1'b1;
        end
        w_busy_nxt[ZERO_ADDR] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign bus.hazard1 = r_busy[bus.chk_a1];
    assign bus.hazard2 = r_busy[bus.chk_a2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven check of the writeback arbiter: arbitration,
// write latency, scoreboard hazards, zero register and reset behaviour.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NV = 25;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        rv;
        logic [4:0]  ra;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic        r0;
        logic        r1;
        logic        rr;
        logic        h1;
        logic        h2;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs [NV];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(
        input int unsigned v0, a0, d0, v1, a1, d1, rv, ra, c1, c2,
        input int unsigned r0, r1, rr, h1, h2, we, a3, wd);
        vec_t v;
        v.v0 = 1'(v0); v.a0 = 5'(a0); v.d0 = 32'(d0);
        v.v1 = 1'(v1); v.a1 = 5'(a1); v.d1 = 32'(d1);
        v.rv = 1'(rv); v.ra = 5'(ra); v.c1 = 5'(c1); v.c2 = 5'(c2);
        v.r0 = 1'(r0); v.r1 = 1'(r1); v.rr = 1'(rr);
        v.h1 = 1'(h1); v.h2 = 1'(h2);
        v.we = 1'(we); v.a3 = 5'(a3); v.wd = 32'(wd);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.rsv_valid  = 1'b0; bus.rsv_addr  = '0;
        bus.chk_a1     = '0;   bus.chk_a2    = '0;
    endtask

    task automatic apply(input vec_t v);
        bus.req0_valid = v.v0; bus.req0_addr = v.a0; bus.req0_data = v.d0;
        bus.req1_valid = v.v1; bus.req1_addr = v.a1; bus.req1_data = v.d1;
        bus.rsv_valid  = v.rv; bus.rsv_addr  = v.ra;
        bus.chk_a1     = v.c1; bus.chk_a2    = v.c2;
    endtask

    initial begin
        //            v0 a0 d0           v1 a1 d1    rv ra  c1  c2  r0 r1 rr h1 h2 we a3  wd
        vecs[0]  = mk(0, 0, 0,           0, 0, 0,    0, 0,  0,  0,  0, 0, 1, 0, 0, 0, 0,  0);
        vecs[1]  = mk(1, 5, 32'hDEADBEEF,0, 0, 0,    0, 0,  0,  0,  1, 0, 1, 0, 0, 0, 0,  0);
        vecs[2]  = mk(0, 0, 0,           0, 0, 0,    0, 0,  0,  0,  0, 0, 1, 0, 0, 1, 5,  32'hDEADBEEF);
        vecs[3]  = mk(0, 0, 0,           0, 0, 0,    0, 0,  0,  0,  0, 0, 1, 0, 0, 0, 5,  32'hDEADBEEF);
        vecs[4]  = mk(0, 0, 0,           1, 3, 'h33, 0, 0,  0,  0,  0, 1, 1, 0, 0, 0, 5,  32'hDEADBEEF);
        vecs[5]  = mk(1, 1, 'h11,        1, 2, 'h22, 0, 0,  0,  0,  1, 0, 1, 0, 0, 1, 3,  'h33);
        vecs[6]  = mk(1, 1, 'h11,        1, 2, 'h22, 0, 0,  0,  0,  0, 1, 1, 0, 0, 1, 1,  'h11);
        vecs[7]  = mk(1, 1, 'h11,        1, 2, 'h22, 0, 0,  0,  0,  1, 0, 1, 0, 0, 1, 2,  'h22);
        vecs[8]  = mk(1, 1, 'h11,        1, 2, 'h22, 0, 0,  0,  0,  0, 1, 1, 0, 0, 1, 1,  'h11);
        vecs[9]  = mk(0, 0, 0,           0, 0, 0,    0, 0,  0,  0,  0, 0, 1, 0, 0, 1, 2,  'h22);
        vecs[10] = mk(0, 0, 0,           0, 0, 0,    0, 0,  0,  0,  0, 0, 1, 0, 0, 0, 2,  'h22);
        vecs[11] = mk(0, 0, 0,           0, 0, 0,    1, 7,  7,  0,  0, 0, 1, 0, 0, 0, 2,  'h22);
        vecs[12] = mk(0, 0, 0,           0, 0, 0,    1, 7,  7,  0,  0, 0, 0, 1, 0, 0, 2,  'h22);
        vecs[13] = mk(0, 0, 0,           1, 7, 'h77, 0, 0,  7,  0,  0, 1, 1, 1, 0, 0, 2,  'h22);
        vecs[14] = mk(0, 0, 0,           0, 0, 0,    0, 0,  7,  0,  0, 0, 1, 1, 0, 1, 7,  'h77);
        vecs[15] = mk(0, 0, 0,           0, 0, 0,    0, 0,  7,  0,  0, 0, 1, 0, 0, 0, 7,  'h77);
        vecs[16] = mk(1, 9, 'h90,        1, 9, 'h91, 0, 0,  0,  9,  1, 0, 1, 0, 0, 0, 7,  'h77);
        vecs[17] = mk(0, 0, 0,           1, 9, 'h91, 0, 0,  0,  9,  0, 1, 1, 0, 0, 1, 9,  'h90);
        vecs[18] = mk(0, 0, 0,           0, 0, 0,    0, 0,  0,  0,  0, 0, 1, 0, 0, 1, 9,  'h91);
        vecs[19] = mk(1, 0, 'h1,         0, 0, 0,    0, 0,  0,  0,  1, 0, 1, 0, 0, 0, 9,  'h91);
        vecs[20] = mk(0, 0, 0,           0, 0, 0,    1, 0,  0,  0,  0, 0, 1, 0, 0, 0, 9,  'h91);
        vecs[21] = mk(0, 0, 0,           0, 0, 0,    0, 0,  0,  0,  0, 0, 1, 0, 0, 0, 9,  'h91);
        vecs[22] = mk(1, 12,'hC,         0, 0, 0,    0, 0,  0,  0,  1, 0, 1, 0, 0, 0, 9,  'h91);
        vecs[23] = mk(0, 0, 0,           0, 0, 0,    1, 12, 12, 0,  0, 0, 1, 0, 0, 1, 12, 'hC);
        vecs[24] = mk(0, 0, 0,           0, 0, 0,    0, 0,  12, 0,  0, 0, 1, 1, 0, 0, 12, 'hC);

        // Reset held with a pending request
        rst = 1'b0;
        idle();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'h1234;
        bus.rsv_valid  = 1'b1; bus.rsv_addr  = 5'd4;
        repeat (2) @(negedge clk);
        #1;
        check("rst req0_ready", 64'(bus.req0_ready), 64'd0);
        check("rst rsv_ready",  64'(bus.rsv_ready),  64'd0);
        check("rst we3",        64'(bus.we3),        64'd0);
        check("rst a3",         64'(bus.a3),         64'd0);
        check("rst wd3",        64'(bus.wd3),        64'd0);
        check("rst hazard1",    64'(bus.hazard1),    64'd0);
        check("rst hazard2",    64'(bus.hazard2),    64'd0);
        @(negedge clk);
        idle();
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check($sformatf("v%0d req0_ready", i), 64'(bus.req0_ready), 64'(vecs[i].r0));
            check($sformatf("v%0d req1_ready", i), 64'(bus.req1_ready), 64'(vecs[i].r1));
            check($sformatf("v%0d rsv_ready", i),  64'(bus.rsv_ready),  64'(vecs[i].rr));
            check($sformatf("v%0d hazard1", i),    64'(bus.hazard1),    64'(vecs[i].h1));
            check($sformatf("v%0d hazard2", i),    64'(bus.hazard2),    64'(vecs[i].h2));
            check($sformatf("v%0d we3", i),        64'(bus.we3),        64'(vecs[i].we));
            check($sformatf("v%0d a3", i),         64'(bus.a3),         64'(vecs[i].a3));
            check($sformatf("v%0d wd3", i),        64'(bus.wd3),        64'(vecs[i].wd));
        end

        // Reset while a write is being presented (busy[12] is set here)
        @(negedge clk);
        idle();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd13; bus.req0_data = 32'hAB;
        bus.chk_a1 = 5'd12;
        #1;
        check("midrst req0_ready", 64'(bus.req0_ready), 64'd1);
        check("midrst pre hazard1", 64'(bus.hazard1), 64'd1);
        @(negedge clk);
        idle();
        bus.chk_a1 = 5'd12;
        #1;
        check("midrst we3 before", 64'(bus.we3), 64'd1);
        check("midrst a3 before",  64'(bus.a3),  64'd13);
        #1 rst = 1'b0;
        #1;
        check("midrst we3 dropped", 64'(bus.we3),     64'd0);
        check("midrst busy clear",  64'(bus.hazard1), 64'd0);
        bus.req0_valid = 1'b1; bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd3;
        #1;
        check("midrst req0_ready", 64'(bus.req0_ready), 64'd0);
        check("midrst rsv_ready",  64'(bus.rsv_ready),  64'd0);
        repeat (2) @(negedge clk);
        idle();
        bus.chk_a1 = 5'd12;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("post rst we3 c%0d", k), 64'(bus.we3), 64'd0);
            check($sformatf("post rst hz c%0d", k),  64'(bus.hazard1), 64'd0);
            @(negedge clk);
        end

        // First tie after reset goes to req0
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'h5A;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 32'hA5;
        #1;
        check("post rst tie r0", 64'(bus.req0_ready), 64'd1);
        check("post rst tie r1", 64'(bus.req1_ready), 64'd0);
        @(negedge clk);
        idle();
        #1;
        check("post rst we3", 64'(bus.we3), 64'd1);
        check("post rst a3",  64'(bus.a3),  64'd1);
        check("post rst wd3", 64'(bus.wd3), 64'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
